// File: rtl/serial_mag_comparator.sv
// Bit-serial MSB-first magnitude comparator: latches an operand pair on start,
// walks one bit per clock and presents a held aeb/agb/alb result with a done strobe.
module serial_mag_comparator #(
   parameter int WIDTH      = 8,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             aeb,
   output logic             agb,
   output logic             alb
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             dec_q, dec_d;
   logic             dgt_q, dgt_d;
   logic             dlt_q, dlt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             aeb_q, aeb_d;
   logic             agb_q, agb_d;
   logic             alb_q, alb_d;

   logic gt_s, lt_s, fin_gt_s, fin_lt_s, exit_s;

   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      cnt_d   = cnt_q;
      dec_d   = dec_q;
      dgt_d   = dgt_q;
      dlt_d   = dlt_q;
      aeb_d   = aeb_q;
      agb_d   = agb_q;
      alb_d   = alb_q;

      gt_s     = sa_q[WIDTH-1] & ~sb_q[WIDTH-1];
      lt_s     = ~sa_q[WIDTH-1] & sb_q[WIDTH-1];
      // Without early exit the first differing bit wins; later bits are ignored.
      fin_gt_s = dec_q ? dgt_q : gt_s;
      fin_lt_s = dec_q ? dlt_q : lt_s;
      exit_s   = (EARLY_EXIT && (gt_s || lt_s)) || (cnt_q == CNT_ONE);

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               sa_d    = a;
               sb_d    = b;
               cnt_d   = CNT_LOAD;
               dec_d   = 1'b0;
               dgt_d   = 1'b0;
               dlt_d   = 1'b0;
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            sa_d  = sa_q << 1;
            sb_d  = sb_q << 1;
            cnt_d = cnt_q - CNT_ONE;
            if (!dec_q && (gt_s || lt_s)) begin
               dec_d = 1'b1;
               dgt_d = gt_s;
               dlt_d = lt_s;
            end else begin
               dec_d = dec_q;
            end
            if (exit_s) begin
               state_d = DONE;
               agb_d   = fin_gt_s;
               alb_d   = fin_lt_s;
               aeb_d   = ~(fin_gt_s | fin_lt_s);
            end else begin
               state_d = SHIFT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == SHIFT);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         cnt_q   <= '0;
         dec_q   <= 1'b0;
         dgt_q   <= 1'b0;
         dlt_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         aeb_q   <= 1'b0;
         agb_q   <= 1'b0;
         alb_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         cnt_q   <= cnt_d;
         dec_q   <= dec_d;
         dgt_q   <= dgt_d;
         dlt_q   <= dlt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         aeb_q   <= aeb_d;
         agb_q   <= agb_d;
         alb_q   <= alb_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign aeb  = aeb_q;
   assign agb  = agb_q;
   assign alb  = alb_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Randomized self-checking bench for serial_mag_comparator across three builds:
// dut 0 = WIDTH 8 early exit, dut 1 = WIDTH 8 full walk, dut 2 = WIDTH 1.
module tb_serial_mag_comparator;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] start_v = 3'b000;
   logic [7:0] a_v = 8'h00;
   logic [7:0] b_v = 8'h00;
   wire  [2:0] busy_v, done_v, aeb_v, agb_v, alb_v;

   int err_cnt = 0;
   int chk_cnt = 0;

   always #5 clk = ~clk;

   serial_mag_comparator #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_dut_ee (
      .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v), .b(b_v),
      .busy(busy_v[0]), .done(done_v[0]), .aeb(aeb_v[0]), .agb(agb_v[0]), .alb(alb_v[0]));

   serial_mag_comparator #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_dut_full (
      .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v), .b(b_v),
      .busy(busy_v[1]), .done(done_v[1]), .aeb(aeb_v[1]), .agb(agb_v[1]), .alb(alb_v[1]));

   serial_mag_comparator #(.WIDTH(1), .EARLY_EXIT(1'b1)) u_dut_w1 (
      .clk(clk), .rst(rst), .start(start_v[2]), .a(a_v[0:0]), .b(b_v[0:0]),
      .busy(busy_v[2]), .done(done_v[2]), .aeb(aeb_v[2]), .agb(agb_v[2]), .alb(alb_v[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: result from plain unsigned comparison, latency from the highest differing bit.
   function automatic void model(input logic [7:0] av, input logic [7:0] bv, input int w,
                                 input bit ee, output logic [2:0] res, output int k);
      int p;
      p = -1;
      for (int i = 0; i < w; i++)
         if (av[i] != bv[i]) p = i;
      if (av == bv)     res = 3'b100;
      else if (av > bv) res = 3'b010;
      else              res = 3'b001;
      k = (ee && p >= 0) ? (w - p) : w;
   endfunction

   function automatic logic [2:0] result(input int sel);
      return {aeb_v[sel], agb_v[sel], alb_v[sel]};
   endfunction

   // Called just after an accepting edge; counts edges until done, and busy cycles seen.
   task automatic wait_done(input int sel, input int budget, output int n, output int busy_n);
      n = 0;
      busy_n = 0;
      while (!done_v[sel] && n < budget) begin
         if (busy_v[sel]) busy_n++;
         @(posedge clk); #1;
         n++;
      end
      if (!done_v[sel]) check("timeout", 32'd0, 32'd1);
   endtask

   task automatic run_cmp(input int sel, input logic [7:0] av_in, input logic [7:0] bv_in);
      int w, k, n, busy_n;
      bit ee;
      logic [7:0] av, bv;
      logic [2:0] exp_res;
      w  = (sel == 2) ? 1 : 8;
      ee = (sel != 1);
      av = (w == 1) ? (av_in & 8'h01) : av_in;
      bv = (w == 1) ? (bv_in & 8'h01) : bv_in;
      model(av, bv, w, ee, exp_res, k);
      @(negedge clk);
      a_v = av; b_v = bv;
      start_v[sel] = 1'b1;
      @(posedge clk); #1;
      start_v[sel] = 1'b0;
      wait_done(sel, w + 4, n, busy_n);
      check($sformatf("lat d%0d %h/%h", sel, av, bv), n, k);
      check($sformatf("busycyc d%0d", sel), busy_n, k);
      check($sformatf("busy@done d%0d", sel), {31'd0, busy_v[sel]}, 32'd0);
      check($sformatf("res d%0d %h/%h", sel, av, bv), {29'd0, result(sel)}, {29'd0, exp_res});
      @(posedge clk); #1;
      check($sformatf("strobe d%0d", sel), {31'd0, done_v[sel]}, 32'd0);
      check($sformatf("hold d%0d", sel), {29'd0, result(sel)}, {29'd0, exp_res});
   endtask

   initial begin
      int n, busy_n, pulses;
      logic [7:0] ra, rb;

      repeat (2) @(posedge clk);
      #1;
      check("rst busy", {29'd0, busy_v}, 32'd0);
      check("rst done", {29'd0, done_v}, 32'd0);
      check("rst res", {23'd0, aeb_v, agb_v, alb_v}, 32'd0);
      rst = 1'b0;

      run_cmp(0, 8'hA5, 8'h25);
      run_cmp(0, 8'h3C, 8'h3C);
      run_cmp(1, 8'h01, 8'h80);
      run_cmp(1, 8'h81, 8'h80);

      // Back-to-back, with operand changes and a restart request while busy.
      @(negedge clk);
      a_v = 8'h10; b_v = 8'h20; start_v[0] = 1'b1;
      @(posedge clk); #1;
      a_v = 8'h20; b_v = 8'h10;
      wait_done(0, 12, n, busy_n);
      check("b2b lat1", n, 32'd3);
      check("b2b res1", {29'd0, result(0)}, 32'd1);
      @(posedge clk); #1;
      check("b2b nogap busy", {31'd0, busy_v[0]}, 32'd1);
      check("b2b done1 len", {31'd0, done_v[0]}, 32'd0);
      a_v = 8'h00; b_v = 8'hFF;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      wait_done(0, 12, n, busy_n);
      check("b2b lat2", n, 32'd2);
      check("b2b res2", {29'd0, result(0)}, 32'd2);

      // Reset in the middle of a full-width walk.
      @(negedge clk);
      a_v = 8'hFF; b_v = 8'h00; start_v[1] = 1'b1;
      @(posedge clk); #1;
      start_v[1] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midrst busy", {31'd0, busy_v[1]}, 32'd0);
      check("midrst res", {29'd0, result(1)}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (done_v[1]) pulses++;
      end
      check("midrst nodone", pulses, 32'd0);
      check("midrst idle res", {29'd0, result(1)}, 32'd0);
      run_cmp(1, 8'h5A, 8'h5B);

      run_cmp(2, 8'h00, 8'h00);
      run_cmp(2, 8'h01, 8'h01);
      run_cmp(2, 8'h01, 8'h00);
      run_cmp(2, 8'h00, 8'h01);

      for (int sel = 0; sel < 3; sel++) begin
         for (int it = 0; it < 30; it++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            case ($urandom_range(2, 0))
               0: rb = ra;
               1: rb = ra ^ (8'h01 << $urandom_range(7, 0));
               default: ;
            endcase
            run_cmp(sel, ra, rb);
         end
      end

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/serial_mag_comparator.md
Name: serial_mag_comparator

Overview:
- Bit-serial, MSB-first magnitude comparator for two WIDTH-bit operands, built around the 1-bit equal/greater/less cell applied once per clock.
- Acts as the sequential stage beside the combinational comparators. It latches an operand pair on a start pulse, walks the bits over successive cycles and cascades the per-bit decision.
- Presents a registered aeb/agb/alb result with a one-cycle done strobe.
- Used where a wide parallel comparator is too costly.

Parameters:
- WIDTH, 8, operand width in bits; legal range 1..32.
- EARLY_EXIT, 1, when 1 the comparison terminates at the first differing bit; when 0 it always takes WIDTH compare cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a comparison; a and b are sampled on the same edge.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- busy  output  1  high while a comparison is in progress (SHIFT state).
- done  output  1  one-cycle strobe; the result is valid and newly updated.
- aeb  output  1  A equals B (held result).
- agb  output  1  A greater than B (held result).
- alb  output  1  A less than B (held result).

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, aeb=0, agb=0, alb=0; shift registers and bit counter cleared. Outputs stay at 0 until the first completed comparison.
- States: IDLE, SHIFT, DONE. busy=1 only in SHIFT; done=1 only in DONE.
- IDLE/DONE with start=1 at an edge:
  - load sa<=a, sb<=b, cnt<=WIDTH; go to SHIFT.
  - Clear internal decided flags; held outputs are NOT changed yet.
- IDLE/DONE with start=0: DONE goes to IDLE; IDLE stays.
- Back-to-back operation: start accepted in DONE gives done high for exactly one cycle, then SHIFT.
- SHIFT, each edge: compare x=sa[WIDTH-1], y=sb[WIDTH-1].
  - gt = x & ~y; lt = ~x & y.
  - Shift sa, sb left by 1 (zero fill); cnt<=cnt-1.
- SHIFT exit condition: (EARLY_EXIT=1 and gt|lt) or cnt==1. On exit:
  - go to DONE.
  - Register agb<=gt, alb<=lt, aeb<=~(gt|lt).
  - With EARLY_EXIT=0, the first differing bit is latched in an internal flag. Later bits are ignored, and the final result comes from that flag.
- Exactly one of aeb/agb/alb is high after any done; the result holds until the next completion or reset.
- start while busy=1 is ignored: no restart, operands are not resampled, and a/b changes have no effect.
- Latency: with start sampled at edge 0, the k-th compare happens at edge k. done is high in the cycle after edge k.
  - k = index of the first differing bit from the MSB, plus 1, when EARLY_EXIT=1 and the operands differ.
  - k = WIDTH otherwise.
  - Maximum start-to-done latency is WIDTH+1 edges; minimum is 2 edges.
- WIDTH=1: a single SHIFT cycle, and cnt==1 always triggers exit.
- Reset mid-SHIFT: immediate return to IDLE, outputs cleared, no done pulse.
- Unsigned arithmetic only; no X propagation from unused shifted-in bits.

Test Plan:
1. WIDTH=8, EARLY_EXIT=1: a=8'hA5, b=8'h25, start one cycle -> first compare decides at bit 7. done high 2 edges after start; agb=1, aeb=0, alb=0; busy high 1 cycle.
2. WIDTH=8, EARLY_EXIT=1: a=8'h3C, b=8'h3C -> busy 8 cycles, done 9 edges after start; aeb=1, agb=0, alb=0.
3. WIDTH=8, EARLY_EXIT=0: a=8'h01, b=8'h80 -> done exactly 9 edges after start; alb=1. Repeat with a=8'h81, b=8'h80: agb=1, with the same latency.
4. Back-to-back: start held high across the DONE cycle with a=8'h10, b=8'h20 then a=8'h20, b=8'h10 -> two done pulses; first gives alb=1, second gives agb=1. No idle cycle between. Pulse start again mid-SHIFT with new a/b -> ignored, result unchanged.
5. Reset mid-op: start a=8'hFF, b=8'h00 with EARLY_EXIT=0, assert rst for one cycle after 3 edges -> busy=0, done never pulses, aeb/agb/alb=0. A new start afterwards completes normally.
6. WIDTH=1 build: all four (a,b) pairs -> done 2 edges after start each time. Results: (0,0)/(1,1) give aeb=1, (1,0) gives agb=1, (0,1) gives alb=1.
